// File: rtl/pcm_mix_pkg.sv
// Shared constants, types and helpers for the multi-channel PCM-to-PWM output stage.
package pcm_mix_pkg;

  localparam int PCM_W_DEFAULT = 8;
  localparam int N_CH_MAX      = 8;

  typedef logic [PCM_W_DEFAULT-1:0] pcm_t;

  // Ceiling log2, used as the averaging shift for the mix path.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < value) result = k + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pcm_chan_buf.sv
// One PCM channel: single-entry holding buffer, active sample, sticky underrun and PWM comparator.
module pcm_chan_buf #(
  parameter int SAMPLE_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] cnt,
  input  logic                load,
  input  logic                ch_en,
  input  logic                clr_underrun,
  input  logic                s_vld,
  input  logic [SAMPLE_W-1:0] s_data,
  output logic                s_rdy,
  output logic                pwm_out,
  output logic                underrun,
  output logic [SAMPLE_W-1:0] next_active
);

  logic [SAMPLE_W-1:0] sample_buf;
  logic [SAMPLE_W-1:0] active;
  logic                full;
  logic                accept;

  assign s_rdy  = ~full;
  assign accept = s_vld & ~full;

  // Value the active register will hold after this edge; the mixer sums these on the load edge.
  assign next_active = (load && full) ? sample_buf : active;

  // Buffer swap on the period boundary, stream accept otherwise, sticky underrun, PWM compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_buf <= '0;
      active     <= '0;
      full       <= 1'b0;
      underrun   <= 1'b0;
      pwm_out    <= 1'b0;
    end else begin
      if (load && full) begin
        active <= sample_buf;
        full   <= 1'b0;
      end else if (accept) begin
        // An accept on the load edge lands here too: it missed this boundary and waits a period.
        sample_buf <= s_data;
        full       <= 1'b1;
      end

      // A set on the same edge wins over a clear.
      if (load && !full && ch_en) begin
        underrun <= 1'b1;
      end else if (clr_underrun) begin
        underrun <= 1'b0;
      end

      pwm_out <= ch_en & (cnt < active);
    end
  end

endmodule

// File: rtl/pcm_mix_pwm.sv
// N-channel PCM-to-PWM output stage with double-buffered samples and an averaged mix output.
module pcm_mix_pwm
  import pcm_mix_pkg::*;
#(
  parameter int N_CH     = N_CH_MAX,
  parameter int SAMPLE_W = PCM_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH*SAMPLE_W-1:0] s_data,
  input  logic [N_CH-1:0]          s_vld,
  output logic [N_CH-1:0]          s_rdy,
  input  logic [N_CH-1:0]          ch_en,
  input  logic                     clr_underrun,
  output logic                     period_start,
  output logic [N_CH-1:0]          pwm_out,
  output logic                     mix_out,
  output logic [N_CH-1:0]          underrun
);

  localparam int MIX_SH = clog2(N_CH);
  localparam int SUM_W  = SAMPLE_W + MIX_SH;
  localparam logic [SAMPLE_W-1:0] CNT_MAX = '1;

  logic [SAMPLE_W-1:0]      cnt;
  logic [SAMPLE_W-1:0]      mix;
  logic                     load;
  logic [N_CH*SAMPLE_W-1:0] next_active;
  logic [SUM_W-1:0]         mix_sum;

  assign load = (cnt == CNT_MAX);

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    pcm_chan_buf #(
      .SAMPLE_W(SAMPLE_W)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .cnt         (cnt),
      .load        (load),
      .ch_en       (ch_en[g]),
      .clr_underrun(clr_underrun),
      .s_vld       (s_vld[g]),
      .s_data      (s_data[g*SAMPLE_W +: SAMPLE_W]),
      .s_rdy       (s_rdy[g]),
      .pwm_out     (pwm_out[g]),
      .underrun    (underrun[g]),
      .next_active (next_active[g*SAMPLE_W +: SAMPLE_W])
    );
  end

  // Sum of the enabled channels' upcoming samples; wide enough that it never overflows.
  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_en[i]) mix_sum = mix_sum + SUM_W'(next_active[i*SAMPLE_W +: SAMPLE_W]);
    end
  end

  // Free-running period counter, boundary pulse, mix latch on the boundary and mix comparator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      period_start <= 1'b0;
      mix          <= '0;
      mix_out      <= 1'b0;
    end else begin
      cnt          <= cnt + 1'b1;
      period_start <= load;
      if (load) mix <= SAMPLE_W'(mix_sum >> MIX_SH);
      mix_out      <= (cnt < mix);
    end
  end

endmodule
